// File: rtl/trig_capture_pkg.sv
// Shared types and defaults for the trig_capture block: FSM state encoding,
// default widths, counter saturation limit and the holdoff timer width helper.
package trig_capture_pkg;

    localparam int DEF_N           = 32;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_HOLDOFF_CYC = 16;

    // Saturation ceiling of the event-cycle counter at the default width.
    localparam int unsigned DEF_CNT_MAX = (1 << DEF_CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // A zero holdoff still needs a one-bit register to keep the port legal.
    function automatic int timer_width(input int cyc);
        return (cyc > 0) ? $clog2(cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/trig_capture_if.sv
// Host/trigger-side bundle of trig_capture: trigger inputs, mask, ack strobe
// and the snapshot/status outputs.  master = host/driver, slave = capture block.
interface trig_capture_if
    import trig_capture_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
);
    logic [N-1:0]     ep_trigger;
    logic [N-1:0]     trig_mask;
    logic             ack;
    logic [N-1:0]     trig_held;
    logic [N-1:0]     ovr_held;
    logic [CNT_W-1:0] cnt_held;
    logic             pending;
    logic             irq;

    modport master (
        output ep_trigger, trig_mask, ack,
        input  trig_held, ovr_held, cnt_held, pending, irq
    );

    modport slave (
        input  ep_trigger, trig_mask, ack,
        output trig_held, ovr_held, cnt_held, pending, irq
    );
endinterface

// File: rtl/trig_holdoff_timer.sv
// Down-counter that suppresses irq after an ack: loads HOLDOFF_CYC-1,
// decrements while enabled and flags done when it reaches zero.
module trig_holdoff_timer
    import trig_capture_pkg::*;
#(
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int W = timer_width(HOLDOFF_CYC);
    localparam logic [W-1:0] LOAD_VAL = (HOLDOFF_CYC > 0) ? W'(HOLDOFF_CYC - 1) : '0;

    logic [W-1:0] timer;

    always_ff @(posedge sys_clk) begin
        if (reset)
            timer <= '0;
        else if (load)
            timer <= LOAD_VAL;
        else if (en && timer != '0)
            timer <= timer - W'(1);
    end

    assign done = (timer == '0);

endmodule

// File: rtl/trig_capture.sv
// Sticky trigger capture with atomic ack snapshot and rate-limited irq.
// Define TRIG_CAPTURE_EDGE_DETECT_EN to capture rising edges instead of levels.
module trig_capture
    import trig_capture_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
    input  logic           sys_clk,
    input  logic           reset,
    trig_capture_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0]     ev;
    logic [N-1:0]     latch;
    logic [N-1:0]     ovr_lat;
    logic [CNT_W-1:0] cnt_lat;
    logic [N-1:0]     trig_held_r;
    logic [N-1:0]     ovr_held_r;
    logic [CNT_W-1:0] cnt_held_r;

    state_t state, state_nxt;
    logic   timer_load;
    logic   timer_en;
    logic   timer_done;
    logic   irq_c;

`ifdef TRIG_CAPTURE_EDGE_DETECT_EN
    logic [N-1:0] trig_prev;

    always_ff @(posedge sys_clk) begin
        if (reset)
            trig_prev <= '0;
        else
            trig_prev <= bus.ep_trigger;
    end

    assign ev = bus.ep_trigger & ~trig_prev & bus.trig_mask;
`else
    assign ev = bus.ep_trigger & bus.trig_mask;
`endif

    // Events coincident with ack start the fresh latch, so nothing is lost or double-reported.
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            latch       <= '0;
            ovr_lat     <= '0;
            cnt_lat     <= '0;
            trig_held_r <= '0;
            ovr_held_r  <= '0;
            cnt_held_r  <= '0;
        end else if (bus.ack) begin
            trig_held_r <= latch;
            ovr_held_r  <= ovr_lat;
            cnt_held_r  <= cnt_lat;
            latch       <= ev;
            ovr_lat     <= '0;
            cnt_lat     <= (|ev) ? CNT_W'(1) : '0;
        end else begin
            latch   <= latch | ev;
            ovr_lat <= ovr_lat | (ev & latch);
            if ((|ev) && cnt_lat != CNT_MAX)
                cnt_lat <= cnt_lat + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (|latch) state_nxt = PENDING;
            PENDING: if (bus.ack) state_nxt = (HOLDOFF_CYC == 0) ? IDLE : HOLDOFF;
            HOLDOFF: if (timer_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq_c      = (state == PENDING);
        timer_load = (state == PENDING) && bus.ack && (HOLDOFF_CYC != 0);
        timer_en   = (state == HOLDOFF);
    end

    trig_holdoff_timer #(
        .HOLDOFF_CYC (HOLDOFF_CYC)
    ) u_holdoff (
        .sys_clk (sys_clk),
        .reset   (reset),
        .load    (timer_load),
        .en      (timer_en),
        .done    (timer_done)
    );

    assign bus.trig_held = trig_held_r;
    assign bus.ovr_held  = ovr_held_r;
    assign bus.cnt_held  = cnt_held_r;
    assign bus.pending   = |latch;
    assign bus.irq       = irq_c;

endmodule

// File: tb/tb_trig_capture.sv
// Directed self-checking bench for trig_capture (N=32, CNT_W=8, HOLDOFF_CYC=16);
// expectations follow TRIG_CAPTURE_EDGE_DETECT_EN when the build defines it.
module tb_trig_capture;
    import trig_capture_pkg::*;

    localparam int N           = 32;
    localparam int CNT_W       = 8;
    localparam int HOLDOFF_CYC = 16;

    logic sys_clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    trig_capture_if #(.N(N), .CNT_W(CNT_W)) bus ();

    trig_capture #(
        .N           (N),
        .CNT_W       (CNT_W),
        .HOLDOFF_CYC (HOLDOFF_CYC)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic check_snap(input string tag, input logic [31:0] t, input logic [31:0] o,
                              input logic [7:0] c);
        check({tag, "_trig"}, 64'(bus.trig_held), 64'(t));
        check({tag, "_ovr"},  64'(bus.ovr_held),  64'(o));
        check({tag, "_cnt"},  64'(bus.cnt_held),  64'(c));
    endtask

    initial begin
        bus.ep_trigger = '0;
        bus.trig_mask  = '1;
        bus.ack        = 1'b0;
        reset          = 1'b1;
        ticks(2);
        check_snap("rst", 32'h0, 32'h0, 8'd0);
        check("rst_pending", 64'(bus.pending), 64'd0);
        check("rst_irq",     64'(bus.irq),     64'd0);
        reset = 1'b0;
        tick();

        // Single pulse on bit 0: pending at t+1, irq at t+2, ack snapshots it.
        bus.ep_trigger = 32'h0000_0001;
        tick();
        bus.ep_trigger = '0;
        check("p1_pending_t1", 64'(bus.pending), 64'd1);
        check("p1_irq_t1",     64'(bus.irq),     64'd0);
        tick();
        check("p1_irq_t2",     64'(bus.irq),     64'd1);
        check("p1_held_before_ack", 64'(bus.trig_held), 64'd0);
        do_ack();
        check_snap("p1", 32'h1, 32'h0, 8'd1);
        check("p1_pending_ack", 64'(bus.pending), 64'd0);
        check("p1_irq_ack",     64'(bus.irq),     64'd0);
        ticks(20);
        check("p1_irq_idle",    64'(bus.irq),     64'd0);

        // Bit 1 pulsed at cycles 0 and 5 without ack: second one is an overrun.
        bus.ep_trigger = 32'h0000_0002;
        tick();
        bus.ep_trigger = '0;
        ticks(4);
        bus.ep_trigger = 32'h0000_0002;
        tick();
        bus.ep_trigger = '0;
        do_ack();
        check_snap("ovr", 32'h2, 32'h2, 8'd2);
        ticks(20);

        // Bit 0 coincident with ack while latch holds bit 2.
        bus.ep_trigger = 32'h0000_0004;
        tick();
        bus.ep_trigger = '0;
        tick();
        bus.ep_trigger = 32'h0000_0001;
        do_ack();
        bus.ep_trigger = '0;
        check_snap("coin1", 32'h4, 32'h0, 8'd1);
        check("coin_pending", 64'(bus.pending), 64'd1);
        do_ack();
        check_snap("coin2", 32'h1, 32'h0, 8'd1);
        check("coin2_pending", 64'(bus.pending), 64'd0);
        ticks(20);

        // 300 event cycles; alternating bits give an event every cycle in both capture modes.
        for (int i = 0; i < 300; i++) begin
            bus.ep_trigger = (i % 2 == 0) ? 32'h0000_0001 : 32'h0000_0002;
            tick();
        end
        bus.ep_trigger = '0;
        do_ack();
        check_snap("sat", 32'h3, 32'h3, 8'd255);

        // Event during holdoff: irq low for 16 cycles after ack, high two cycles after IDLE.
        bus.ep_trigger = 32'h0000_0008;
        tick();
        bus.ep_trigger = '0;
        check("hold_irq_1", 64'(bus.irq), 64'd0);
        for (int k = 2; k <= HOLDOFF_CYC; k++) begin
            tick();
            check($sformatf("hold_irq_%0d", k), 64'(bus.irq), 64'd0);
        end
        check("hold_pending", 64'(bus.pending), 64'd1);
        tick();
        check("hold_irq_resume", 64'(bus.irq), 64'd1);
        do_ack();
        check_snap("hold", 32'h8, 32'h0, 8'd1);
        ticks(20);

        // Masked source: no capture.
        bus.trig_mask  = 32'hFFFF_FFFE;
        bus.ep_trigger = 32'h0000_0001;
        tick();
        bus.ep_trigger = '0;
        check("mask_pending", 64'(bus.pending), 64'd0);
        tick();
        check("mask_irq",     64'(bus.irq),     64'd0);
        bus.trig_mask  = '1;

        // Reset mid-operation with latch and held outputs nonzero.
        bus.ep_trigger = 32'h0000_0005;
        tick();
        bus.ep_trigger = '0;
        tick();
        check("prerst_irq", 64'(bus.irq), 64'd1);
        reset = 1'b1;
        tick();
        check_snap("midrst", 32'h0, 32'h0, 8'd0);
        check("midrst_pending", 64'(bus.pending), 64'd0);
        check("midrst_irq",     64'(bus.irq),     64'd0);
        reset = 1'b0;
        tick();

        // Bit 3 held high for 10 cycles.
        bus.ep_trigger = 32'h0000_0008;
        ticks(10);
        bus.ep_trigger = '0;
        do_ack();
`ifdef TRIG_CAPTURE_EDGE_DETECT_EN
        check_snap("level", 32'h8, 32'h0, 8'd1);
`else
        check_snap("level", 32'h8, 32'h8, 8'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trig_capture.md
Name: trig_capture

Overview:
- Host-facing capture side of the fabric trigger path.
- Accepts single-cycle trigger pulses generated in the sys_clk domain, for example counter-equality events.
- Holds each pulse sticky until the host acknowledges, so no event is lost between host polls.
- On acknowledge, presents an atomic snapshot (triggers, overruns, event count) for wire-out readback, and raises a rate-limited irq.

Parameters:
- N, 32, trigger vector width.
- CNT_W, 8, width of the saturating event-cycle counter.
- HOLDOFF_CYC, 16, irq suppression cycles after an ack; 0 = no holdoff.

Ports:
- sys_clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ep_trigger  in  N  trigger pulses, one bit per source.
- trig_mask  in  N  1 = source enabled; quasi-static.
- ack  in  1  single-cycle host acknowledge/snapshot strobe.
- trig_held  out  N  snapshot of latched triggers at last ack.
- ovr_held  out  N  snapshot of per-bit overrun flags at last ack.
- cnt_held  out  CNT_W  snapshot of event-cycle count at last ack.
- pending  out  1  any trigger currently latched (not yet acked).
- irq  out  1  interrupt request, level.

Behaviour:
- Reset value of every register and output is 0; FSM resets to IDLE.
- ev = ep_trigger & trig_mask (see Optional Feature for the edge mode).
- Latch, per bit, no ack:
  - latch[i] <= latch[i] | ev[i].
  - ovr_lat[i] <= ovr_lat[i] | (ev[i] & latch[i]): an event on an already-latched bit is an overrun.
- Latch on ack (atomic, same edge):
  - trig_held <= latch; ovr_held <= ovr_lat; cnt_held <= cnt_lat.
  - latch <= ev; ovr_lat <= 0.
  - An event coincident with ack lands in the fresh latch: never lost, never double-reported, never an overrun.
- Counter:
  - cnt_lat increments by 1 on each cycle with |ev, saturating at 2^CNT_W-1 (no wrap).
  - On ack, cnt_lat <= (|ev ? 1 : 0).
- pending = |latch, decoded from registered latch only.
- Latency:
  - Event in cycle t -> latch and pending visible at t+1.
  - FSM enters PENDING at t+2; irq high at t+2.
  - ack in cycle t -> held outputs updated at t+1.
- FSM states IDLE, PENDING, HOLDOFF; irq = (state == PENDING), registered decode.
  - IDLE: if |latch -> PENDING.
  - PENDING: on ack -> HOLDOFF with timer <= HOLDOFF_CYC-1, or -> IDLE if HOLDOFF_CYC == 0.
  - HOLDOFF: timer decrements each cycle; at timer == 0 -> IDLE. Events keep latching but irq stays low.
- ack in IDLE or HOLDOFF: snapshot and clear still occur; state and timer are unaffected.
- Masking a bit stops new captures only; an already-latched bit stays until acked.
- reset mid-operation clears latch, ovr_lat, cnt_lat, held outputs and timer; the FSM returns to IDLE on the next edge.

Optional Feature:
- Macro TRIG_CAPTURE_EDGE_DETECT_EN.
- Defined:
  - A registered copy of ep_trigger (reset 0) is kept.
  - ev = ep_trigger & ~trig_prev & trig_mask, i.e. rising edges only.
  - A held-high input produces exactly one event.
- Undefined:
  - ev = ep_trigger & trig_mask.
  - A level held high for K cycles yields K events, so overrun sets from the second cycle.
  - The counter counts K cycles.

Decomposition:
- Package trig_capture_pkg holds:
  - state enum (IDLE, PENDING, HOLDOFF);
  - default-width localparams;
  - counter saturation max constant.
- One sub-module is natural: trig_holdoff_timer (load, decrement, done flag, width $clog2(HOLDOFF_CYC+1)).
- Per-bit capture logic stays inline as a vectored expression.

Test Plan:
- Pulse ep_trigger = 32'h0000_0001 for 1 cycle, mask all-ones -> pending = 1 at t+1, irq = 1 at t+2; ack -> trig_held = 32'h1, ovr_held = 0, cnt_held = 1, pending = 0, irq = 0.
- Pulse bit 1 twice (cycles 0 and 5), no ack -> ack gives trig_held = 32'h2, ovr_held = 32'h2, cnt_held = 2.
- Pulse bit 0 in the same cycle as ack with latch = 32'h4 -> trig_held = 32'h4; next ack -> trig_held = 32'h1, ovr_held = 0.
- 300 event cycles without ack (CNT_W = 8) -> cnt_held = 255 after ack.
- HOLDOFF_CYC = 16, event during holdoff -> irq stays 0 for 16 cycles after ack, then IDLE -> PENDING and irq = 1 two cycles later.
- trig_mask = 32'hFFFF_FFFE, pulse bit 0 -> pending stays 0.
- Assert reset with latch nonzero -> all outputs 0 next cycle.
- EDGE_DETECT build: bit 3 high for 10 cycles -> cnt_held = 1, ovr_held = 0.
